spi_pixel_master: RTL and testbench

SPI initiator that serialises parallel pixels onto the same four-wire link (SCK, CS, SDI, SDO) that the chip's pixel SPI slave (`spi_control`) serves, and collects the processed pixel returned on SDO in the same frame. It sits in bench-side and FPGA-side harnesses, and in a future host bridge, between a parallel pixel source or sink and the `tt_um_gray_sobel` pins ui_in[0]/[1]/[2] and uo_out[0]. It uses one full-duplex frame per pixel in SPI mode 0, MSB first. SCK is derived from the system clock.

---
 rtl/spi_pixel_master_if.sv | 36 +++
 rtl/spi_pixel_master.sv | 148 ++++++++++++++
 tb/tb_spi_pixel_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pixel_master_if.sv
// spi_pixel_master_if
// Bundles the parallel pixel handshake and the four-wire SPI pins of
// spi_pixel_master.
//   tx_px_i / tx_valid_i / tx_ready_o : pixel into the master
//   rx_px_o / rx_valid_o              : pixel returned by the slave
//   busy_o                            : frame or inter-frame gap running
//   spi_sck_o / spi_cs_o / spi_sdi_o  : SPI lines driven towards the slave
//   spi_sdo_i                         : SPI line driven by the slave
// modport master : the SPI initiator itself
// modport slave  : whatever sits around it (pixel source/sink and link)
interface spi_pixel_master_if #(
    parameter int PIXEL_BITS = 8
);
    logic [PIXEL_BITS-1:0] tx_px_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic [PIXEL_BITS-1:0] rx_px_o;
    logic                  rx_valid_o;
    logic                  busy_o;
    logic                  spi_sck_o;
    logic                  spi_cs_o;
    logic                  spi_sdi_o;
    logic                  spi_sdo_i;

    modport master (
        input  tx_px_i, tx_valid_i, spi_sdo_i,
        output tx_ready_o, rx_px_o, rx_valid_o, busy_o,
               spi_sck_o, spi_cs_o, spi_sdi_o
    );

    modport slave (
        output tx_px_i, tx_valid_i, spi_sdo_i,
        input  tx_ready_o, rx_px_o, rx_valid_o, busy_o,
               spi_sck_o, spi_cs_o, spi_sdi_o
    );
endinterface

// File: rtl/spi_pixel_master.sv
// spi_pixel_master
// SPI mode-0 initiator, MSB first, one full-duplex frame per pixel. The
// pixel on tx_px_i is shifted out on SDI while SDO is shifted into an rx
// register; the returned pixel appears on rx_px_o with a one-cycle
// rx_valid_o pulse when CS is released.
// Ports:
//   clk_i    : system clock, rising edge
//   nreset_i : asynchronous active-low reset
//   bus      : pixel handshake + SPI pins (spi_pixel_master_if.master)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | CS high, waiting for tx_valid_i (tx_ready_o high)
// S_SETUP | CS low, SCK low, first data bit settling before first rise
// S_SHIFT | SCK toggling, one high + one low half-period per bit
// S_HOLD  | CS low, SCK low, hold time after the last bit
// S_GAP   | CS high, minimum deselect time before the next accept
module spi_pixel_master #(
    parameter int PIXEL_BITS  = 8,
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 8
) (
    input logic              clk_i,
    input logic              nreset_i,
    spi_pixel_master_if.master bus
);
    localparam int DIV_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int BIT_W   = $clog2(PIXEL_BITS + 1);
    // One IDLE cycle completes the CS-high gap, so GAP itself runs CS_GAP-1
    // cycles and the next accept can land exactly CS_GAP edges after CS rises.
    localparam int GAP_TC  = (CS_GAP > 1) ? CS_GAP - 2 : 0;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t                r_state, w_state_nxt;
    logic [DIV_W-1:0]      r_div, w_div_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt;
    logic [PIXEL_BITS-1:0] r_tx_sr, w_tx_sr_nxt;
    logic [PIXEL_BITS-1:0] r_rx_sr, w_rx_sr_nxt;
    logic [PIXEL_BITS-1:0] r_rx_px, w_rx_px_nxt;
    logic                  r_sck, w_sck_nxt;
    logic                  r_cs, w_cs_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  w_half_tc, w_gap_tc;

    assign w_half_tc = (r_div == DIV_W'(HALF_PERIOD - 1));
    assign w_gap_tc  = (r_div == DIV_W'(GAP_TC));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_px    <= '0;
            r_sck      <= 1'b0;
            r_cs       <= 1'b1;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_rx_px    <= w_rx_px_nxt;
            r_sck      <= w_sck_nxt;
            r_cs       <= w_cs_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div + DIV_W'(1);
        w_bit_nxt      = r_bit;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_rx_px_nxt    = r_rx_px;
        w_sck_nxt      = r_sck;
        w_cs_nxt       = r_cs;
        w_rx_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                if (bus.tx_valid_i) begin
                    w_state_nxt = S_SETUP;
                    w_tx_sr_nxt = bus.tx_px_i;
                    w_cs_nxt    = 1'b0;
                    w_bit_nxt   = '0;
                end
            end
            S_SETUP: begin
                if (w_half_tc) begin
                    w_state_nxt = S_SHIFT;
                    w_sck_nxt   = 1'b1;
                    w_div_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (w_half_tc) begin
                    w_div_nxt = '0;
                    if (r_sck) begin
                        // Falling edge: capture SDO, present the next bit.
                        // The zero fill leaves SDI low after the last bit.
                        w_sck_nxt   = 1'b0;
                        w_rx_sr_nxt = {r_rx_sr[PIXEL_BITS-2:0], bus.spi_sdo_i};
                        w_tx_sr_nxt = {r_tx_sr[PIXEL_BITS-2:0], 1'b0};
                    end else if (r_bit == BIT_W'(PIXEL_BITS - 1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                        w_sck_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_half_tc) begin
                    w_state_nxt    = (CS_GAP > 1) ? S_GAP : S_IDLE;
                    w_cs_nxt       = 1'b1;
                    w_rx_px_nxt    = r_rx_sr;
                    w_rx_valid_nxt = 1'b1;
                    w_div_nxt      = '0;
                end
            end
            S_GAP: begin
                if (w_gap_tc) begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
            end
        endcase
    end

    assign bus.tx_ready_o = (r_state == S_IDLE);
    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.rx_px_o    = r_rx_px;
    assign bus.rx_valid_o = r_rx_valid;
    assign bus.spi_sck_o  = r_sck;
    assign bus.spi_cs_o   = r_cs;
    assign bus.spi_sdi_o  = r_tx_sr[PIXEL_BITS-1];
endmodule

// File: tb/tb_spi_pixel_master.sv
// Directed bench for spi_pixel_master with SDO looped back to SDI.
module tb_spi_pixel_master;
    logic clk;
    logic nreset;
    int   checks = 0;
    int   errors = 0;

    spi_pixel_master_if #(.PIXEL_BITS(8)) bus();
    assign bus.spi_sdo_i = bus.spi_sdi_o;

    spi_pixel_master #(.PIXEL_BITS(8), .HALF_PERIOD(4), .CS_GAP(8)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observations of one frame, relative to its accept edge
    int         n_rise, first_rise, last_fall, cs_rise, rxv_cnt, rxv_t;
    int         ready_t, sck_cs_high;
    logic [7:0] rise_bits, rxv_val;
    logic       cs_at0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_and_watch(input logic [7:0] px, input int ncyc);
        logic prev_sck, prev_cs;
        @(negedge clk);
        bus.tx_px_i    = px;
        bus.tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid_i = 1'b0;
        bus.tx_px_i    = ~px;
        cs_at0 = bus.spi_cs_o;
        n_rise = 0; first_rise = -1; last_fall = -1; cs_rise = -1;
        rxv_cnt = 0; rxv_t = -1; ready_t = -1; sck_cs_high = 0;
        rise_bits = '0; rxv_val = '0;
        prev_sck = bus.spi_sck_o;
        prev_cs  = bus.spi_cs_o;
        for (int t = 1; t <= ncyc; t++) begin
            @(posedge clk);
            #1;
            if (!prev_sck && bus.spi_sck_o) begin
                n_rise++;
                if (first_rise < 0) first_rise = t;
                rise_bits = {rise_bits[6:0], bus.spi_sdi_o};
            end
            if (prev_sck && !bus.spi_sck_o) last_fall = t;
            if ((prev_sck != bus.spi_sck_o) && bus.spi_cs_o) sck_cs_high++;
            if (!prev_cs && bus.spi_cs_o && cs_rise < 0) cs_rise = t;
            if (bus.rx_valid_o) begin
                rxv_cnt++;
                rxv_t   = t;
                rxv_val = bus.rx_px_o;
            end
            if (bus.tx_ready_o && ready_t < 0) ready_t = t;
            prev_sck = bus.spi_sck_o;
            prev_cs  = bus.spi_cs_o;
        end
    endtask

    initial begin
        int         acc_t[3];
        int         n_acc, rdy_cnt, n_rx, sck_idle_edges;
        logic       rdy, prev_sck;
        logic [7:0] rx_seq[3];
        logic [7:0] px_seq[4];

        nreset         = 1'b0;
        bus.tx_px_i    = 8'h00;
        bus.tx_valid_i = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs",    bus.spi_cs_o,   1);
        chk("rst_sck",   bus.spi_sck_o,  0);
        chk("rst_sdi",   bus.spi_sdi_o,  0);
        chk("rst_ready", bus.tx_ready_o, 1);
        chk("rst_busy",  bus.busy_o,     0);
        chk("rst_rxpx",  bus.rx_px_o,    0);
        chk("rst_rxv",   bus.rx_valid_o, 0);

        // after release nothing moves while tx_valid_i stays low
        @(negedge clk);
        nreset = 1'b1;
        sck_idle_edges = 0;
        prev_sck = bus.spi_sck_o;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.spi_cs_o !== 1'b1 || bus.spi_sck_o !== prev_sck) sck_idle_edges++;
            prev_sck = bus.spi_sck_o;
        end
        chk("idle_quiet", sck_idle_edges, 0);

        // loopback of 0xA5 with edge timing (H=4, N=8, G=8)
        send_and_watch(8'hA5, 90);
        chk("a5_cs_fall0",   cs_at0,      0);
        chk("a5_n_rise",     n_rise,      8);
        chk("a5_first_rise", first_rise,  4);
        chk("a5_last_fall",  last_fall,   64);
        chk("a5_cs_rise",    cs_rise,     72);
        chk("a5_rxv_t",      rxv_t,       72);
        chk("a5_rxv_cnt",    rxv_cnt,     1);
        chk("a5_rx",         rxv_val,     8'hA5);
        chk("a5_sdi_bits",   rise_bits,   8'hA5);
        chk("a5_sck_cs_hi",  sck_cs_high, 0);
        // ready is high in the cycle ending at edge 80 so an accept can land there
        chk("a5_ready_t",    ready_t,     79);
        chk("a5_rx_hold",    bus.rx_px_o, 8'hA5);

        // back-to-back with tx_valid_i held high
        px_seq[0] = 8'h00; px_seq[1] = 8'hFF; px_seq[2] = 8'h3C; px_seq[3] = 8'h99;
        n_acc = 0; rdy_cnt = 0; n_rx = 0;
        @(negedge clk);
        bus.tx_px_i    = px_seq[0];
        bus.tx_valid_i = 1'b1;
        rdy = bus.tx_ready_o;
        for (int t = 0; t < 400 && n_rx < 3; t++) begin
            @(posedge clk);
            #1;
            if (rdy && bus.tx_valid_i) begin
                acc_t[n_acc] = t;
                n_acc++;
                bus.tx_px_i = px_seq[n_acc];
                if (n_acc == 3) bus.tx_valid_i = 1'b0;
            end
            if (bus.rx_valid_o) begin
                rx_seq[n_rx] = bus.rx_px_o;
                n_rx++;
            end
            rdy = bus.tx_ready_o;
            if (rdy && n_acc >= 1 && n_acc < 3) rdy_cnt++;
        end
        chk("b2b_n_acc", n_acc, 3);
        chk("b2b_n_rx",  n_rx,  3);
        if (n_acc == 3) begin
            chk("b2b_gap1", acc_t[1] - acc_t[0], 80);
            chk("b2b_gap2", acc_t[2] - acc_t[1], 80);
        end
        chk("b2b_ready_pulses", rdy_cnt, 2);
        if (n_rx == 3) begin
            chk("b2b_rx0", rx_seq[0], 8'h00);
            chk("b2b_rx1", rx_seq[1], 8'hFF);
            chk("b2b_rx2", rx_seq[2], 8'h3C);
        end
        repeat (20) @(posedge clk);

        // reset in the middle of a frame
        @(negedge clk);
        bus.tx_px_i    = 8'hC3;
        bus.tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid_i = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        chk("mid_busy_before", bus.busy_o, 1);
        nreset = 1'b0;
        #1;
        chk("mid_cs",    bus.spi_cs_o,   1);
        chk("mid_sck",   bus.spi_sck_o,  0);
        chk("mid_busy",  bus.busy_o,     0);
        chk("mid_ready", bus.tx_ready_o, 1);
        chk("mid_rxpx",  bus.rx_px_o,    0);
        n_rx = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.rx_valid_o) n_rx++;
        end
        chk("mid_no_rxv", n_rx, 0);
        @(negedge clk);
        nreset = 1'b1;
        send_and_watch(8'h5A, 90);
        chk("post_rx",     rxv_val,   8'h5A);
        chk("post_rxv",    rxv_cnt,   1);
        chk("post_n_rise", n_rise,    8);
        chk("post_bits",   rise_bits, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
